// File: rtl/timer_count_controller_pkg.sv
// Shared definitions for the MM:SS countdown datapath.
// Holds the controller state encoding, BCD digit widths and digit limits.
// Imported by bcd_mod60_counter and timer_count_controller.
package timer_count_controller_pkg;

    localparam int TENS_W = 3;
    localparam int ONES_W = 4;

    localparam logic [TENS_W-1:0] MAX_TENS = 3'd5;
    localparam logic [ONES_W-1:0] MAX_ONES = 4'd9;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        SETTING  = 2'd1,
        COUNTING = 2'd2,
        EXPIRED  = 2'd3
    } state_t;

endpackage

// File: rtl/timer_count_controller_bcd_mod60_counter.sv
// bcd_mod60_counter: one mod-60 BCD digit pair (00..59).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   inc               : +1 mod 60 (59 -> 00, never carries out)
//   dec               : -1 mod 60 (00 -> 59)
//   clr               : force 00 (wins over inc/dec)
//   tens, ones        : registered BCD digits
//   is_zero           : registered value is 00
//   borrow_out        : a decrement is wrapping 00 -> 59 this cycle
// Priority inside the counter: reset > clr > inc > dec.
module bcd_mod60_counter
    import timer_count_controller_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    input  logic              clr,
    output logic [TENS_W-1:0] tens,
    output logic [ONES_W-1:0] ones,
    output logic              is_zero,
    output logic              borrow_out
);

    assign is_zero    = (tens == '0) && (ones == '0);
    // Borrow only when the decrement actually takes effect.
    assign borrow_out = dec && !inc && !clr && is_zero;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            if (ones == MAX_ONES) begin
                ones <= '0;
                tens <= (tens == MAX_TENS) ? '0 : tens + 3'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end else if (dec) begin
            if (ones == '0) begin
                ones <= MAX_ONES;
                tens <= (tens == '0) ? MAX_TENS : tens - 3'd1;
            end else begin
                ones <= ones - 4'd1;
            end
        end
    end

endmodule

// File: rtl/timer_count_controller.sv
// timer_count_controller: sequences the MM:SS countdown datapath from the
// timer FSM's enable/forward/reset commands.
// Owns the 1 s prescaler, two mod-60 BCD digit pairs, rising-edge detection
// of the setting buttons and expiry detection.
// Parameters:
//   TICK_DIV   : clk cycles per 1 s tick (>= 2)
//   ALARM_SECS : seconds the alarm blinks after expiry (TIMER_ALARM_EN only)
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   enable_counter     : datapath active
//   forward            : 1 = setting mode, 0 = countdown
//   reset_timer        : clear time to 00:00, back to HOLD
//   seg_demand         : rising edge = +1 second while setting
//   min_demand         : rising edge = +1 minute while setting
//   min_tens..sec_ones : registered BCD time
//   zero               : registered time is 00:00
//   tick               : one-cycle pulse coincident with each decrement
//   alarm              : expiry blink (0 unless TIMER_ALARM_EN is defined)
//   state              : current controller state, for observation
// Build option: define TIMER_ALARM_EN to synthesise the expiry alarm blinker.
module timer_count_controller
    import timer_count_controller_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int ALARM_SECS = 10
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_counter,
    input  logic              forward,
    input  logic              reset_timer,
    input  logic              seg_demand,
    input  logic              min_demand,
    output logic [TENS_W-1:0] min_tens,
    output logic [ONES_W-1:0] min_ones,
    output logic [TENS_W-1:0] sec_tens,
    output logic [ONES_W-1:0] sec_ones,
    output logic              zero,
    output logic              tick,
    output logic              alarm,
    output state_t            state
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic          seg_q;
    logic          min_q;
    logic          seg_rise;
    logic          min_rise;
    state_t        mode;
    state_t        next_state;
    logic          sec_zero;
    logic          min_zero;
    logic          sec_borrow;
    logic          min_borrow;
    logic          time_zero;
    logic          last_sec;
    logic          wrap;
    logic          sec_inc;
    logic          min_inc;
    logic          sec_dec;

    assign seg_rise  = seg_demand && !seg_q;
    assign min_rise  = min_demand && !min_q;
    assign time_zero = sec_zero && min_zero;
    assign zero      = time_zero;
    // 00:01 is the only value a decrement turns into 00:00.
    assign last_sec  = min_zero && (sec_tens == '0) && (sec_ones == 4'd1);

    // Operating mode is taken from the commands every cycle; only EXPIRED
    // is sticky, and it is left solely for setting mode (or reset_timer).
    always_comb begin
        mode = HOLD;
        if (state == EXPIRED && !(enable_counter && forward))
            mode = EXPIRED;
        else if (!enable_counter)
            mode = HOLD;
        else if (forward)
            mode = SETTING;
        else
            mode = COUNTING;
    end

    assign wrap    = (mode == COUNTING) && !time_zero && (presc == TICK_LAST);
    assign sec_inc = (mode == SETTING) && seg_rise && !reset_timer;
    assign min_inc = (mode == SETTING) && min_rise && !reset_timer;
    assign sec_dec = wrap && !reset_timer;

    always_comb begin
        next_state = mode;
        if (reset_timer)
            next_state = HOLD;
        else if (mode == COUNTING && (time_zero || (wrap && last_sec)))
            next_state = EXPIRED;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HOLD;
            presc <= '0;
            tick  <= 1'b0;
            seg_q <= 1'b0;
            min_q <= 1'b0;
        end else begin
            seg_q <= seg_demand;
            min_q <= min_demand;
            state <= next_state;
            tick  <= sec_dec;
            // HOLD and EXPIRED freeze the prescaler so a paused second resumes.
            if (reset_timer || mode == SETTING)
                presc <= '0;
            else if (mode == COUNTING && !time_zero)
                presc <= wrap ? '0 : presc + 1'b1;
        end
    end

    bcd_mod60_counter u_seconds (
        .clk        (clk),
        .reset      (reset),
        .inc        (sec_inc),
        .dec        (sec_dec),
        .clr        (reset_timer),
        .tens       (sec_tens),
        .ones       (sec_ones),
        .is_zero    (sec_zero),
        .borrow_out (sec_borrow)
    );

    bcd_mod60_counter u_minutes (
        .clk        (clk),
        .reset      (reset),
        .inc        (min_inc),
        .dec        (sec_borrow),
        .clr        (reset_timer),
        .tens       (min_tens),
        .ones       (min_ones),
        .is_zero    (min_zero),
        .borrow_out (min_borrow)
    );

`ifdef TIMER_ALARM_EN
    localparam int HALF         = TICK_DIV / 2;
    localparam int ALARM_CYCLES = ALARM_SECS * TICK_DIV;

    logic [31:0] half_cnt;
    logic [31:0] alarm_cnt;
    logic        alarm_r;

    // alarm_cnt counts the cycles the blink has been shown, including the
    // entry cycle; half_cnt paces the toggle every HALF cycles.
    always_ff @(posedge clk) begin
        if (reset || next_state != EXPIRED) begin
            alarm_r   <= 1'b0;
            half_cnt  <= '0;
            alarm_cnt <= '0;
        end else if (state != EXPIRED) begin
            alarm_r   <= 1'b1;
            half_cnt  <= '0;
            alarm_cnt <= 32'd1;
        end else if (alarm_cnt >= 32'(ALARM_CYCLES)) begin
            alarm_r <= 1'b0;
        end else begin
            alarm_cnt <= alarm_cnt + 32'd1;
            if (half_cnt == 32'(HALF - 1)) begin
                half_cnt <= '0;
                alarm_r  <= !alarm_r;
            end else begin
                half_cnt <= half_cnt + 32'd1;
            end
        end
    end

    assign alarm = alarm_r;
`else
    assign alarm = 1'b0;
`endif

    // Minutes never borrow further; the countdown stops at 00:00.
    logic unused_ok;
    assign unused_ok = min_borrow;

endmodule

// File: tb/tb_timer_count_controller.sv
// Testbench for timer_count_controller (TICK_DIV=4, ALARM_SECS=2).
// A reference model keeps the time as a plain number of seconds and is
// compared against every DUT output on each falling edge; directed scenarios
// add hand-computed literal checks, then a randomized phase follows.
// Define TIMER_ALARM_EN for both RTL and bench to check the alarm blink.
module tb_timer_count_controller;
    import timer_count_controller_pkg::*;

    localparam int TD = 4;
    localparam int AS = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable_counter = 1'b0;
    logic       forward = 1'b0;
    logic       reset_timer = 1'b0;
    logic       seg_demand = 1'b0;
    logic       min_demand = 1'b0;
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic       zero;
    logic       tick;
    logic       alarm;
    state_t     state;

    always #5 clk = ~clk;

    timer_count_controller #(.TICK_DIV(TD), .ALARM_SECS(AS)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable_counter (enable_counter),
        .forward        (forward),
        .reset_timer    (reset_timer),
        .seg_demand     (seg_demand),
        .min_demand     (min_demand),
        .min_tens       (min_tens),
        .min_ones       (min_ones),
        .sec_tens       (sec_tens),
        .sec_ones       (sec_ones),
        .zero           (zero),
        .tick           (tick),
        .alarm          (alarm),
        .state          (state)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit check_on = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_t    = 0;   // time in seconds
    int m_p    = 0;   // cycles into the current second
    int m_k    = 0;   // cycles since expiry
    int m_mode = 0;   // 0 hold, 1 setting, 2 counting
    bit m_exp  = 1'b0;
    bit m_tick = 1'b0;
    bit m_sq   = 1'b0;
    bit m_mq   = 1'b0;

    always @(posedge clk) begin
        bit sr, mr;
        int mm, ss;
        sr = seg_demand && !m_sq;
        mr = min_demand && !m_mq;
        m_tick = 1'b0;
        if (reset) begin
            m_t = 0; m_p = 0; m_k = 0; m_mode = 0; m_exp = 1'b0;
            m_sq = 1'b0; m_mq = 1'b0;
        end else begin
            m_sq = seg_demand;
            m_mq = min_demand;
            if (reset_timer) begin
                m_t = 0; m_p = 0; m_exp = 1'b0; m_mode = 0;
            end else if (m_exp && !(enable_counter && forward)) begin
                m_k++;
            end else begin
                m_exp = 1'b0;
                if (!enable_counter) begin
                    m_mode = 0;
                end else if (forward) begin
                    m_mode = 1;
                    m_p = 0;
                    mm = m_t / 60;
                    ss = m_t % 60;
                    if (sr) ss = (ss + 1) % 60;
                    if (mr) mm = (mm + 1) % 60;
                    m_t = mm * 60 + ss;
                end else if (m_t == 0) begin
                    m_mode = 2; m_exp = 1'b1; m_k = 0;
                end else begin
                    m_mode = 2;
                    if (m_p == TD - 1) begin
                        m_p = 0;
                        m_t = m_t - 1;
                        m_tick = 1'b1;
                        if (m_t == 0) begin
                            m_exp = 1'b1; m_k = 0;
                        end
                    end else begin
                        m_p++;
                    end
                end
            end
        end
    end

    function automatic int exp_alarm();
`ifdef TIMER_ALARM_EN
        return int'(m_exp && (m_k < AS * TD) && (((m_k / (TD / 2)) % 2) == 0));
`else
        return 0;
`endif
    endfunction

    always @(negedge clk) begin
        if (check_on) begin
            check("min_tens", int'(min_tens), (m_t / 60) / 10);
            check("min_ones", int'(min_ones), (m_t / 60) % 10);
            check("sec_tens", int'(sec_tens), (m_t % 60) / 10);
            check("sec_ones", int'(sec_ones), (m_t % 60) % 10);
            check("zero", int'(zero), int'(m_t == 0));
            check("tick", int'(tick), int'(m_tick));
            check("alarm", int'(alarm), exp_alarm());
            check("state", int'(state), m_exp ? 3 : m_mode);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_time(input string name, input int mm, input int ss);
        check(name, (int'(min_tens) * 10 + int'(min_ones)) * 100
                    + int'(sec_tens) * 10 + int'(sec_ones), mm * 100 + ss);
    endtask

    // Clears to 00:00, then enters the time with button pulses in setting mode.
    task automatic set_time(input int mm, input int ss);
        int n;
        n = (mm > ss) ? mm : ss;
        reset_timer = 1'b1; enable_counter = 1'b1; forward = 1'b1;
        seg_demand = 1'b0; min_demand = 1'b0;
        cyc();
        reset_timer = 1'b0;
        for (int i = 0; i < n; i++) begin
            seg_demand = (i < ss);
            min_demand = (i < mm);
            cyc();
            seg_demand = 1'b0;
            min_demand = 1'b0;
            cyc();
        end
    endtask

    bit [1:0] pat [8] = '{2'b10, 2'b00, 2'b11, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};

    initial begin
        // 1. reset and idle toggling
        cyc();
        reset = 1'b0;
        check_on = 1'b1;
        check_time("reset_time", 0, 0);
        check("reset_zero", int'(zero), 1);
        check("reset_tick", int'(tick), 0);
        check("reset_alarm", int'(alarm), 0);
        check("reset_state", int'(state), 0);
        for (int i = 0; i < 4; i++) begin
            seg_demand = ~seg_demand;
            cyc();
        end
        check_time("hold_ignores_seg", 0, 0);

        // 2. setting: 3 seconds, 2 minutes (one coincident)
        enable_counter = 1'b1; forward = 1'b1;
        cyc();
        for (int i = 0; i < 8; i++) begin
            seg_demand = pat[i][1];
            min_demand = pat[i][0];
            cyc();
        end
        check_time("set_02_03", 2, 3);
        set_time(0, 59);
        check_time("set_00_59", 0, 59);
        seg_demand = 1'b1;
        cyc();
        check_time("sec_wrap_no_carry", 0, 0);
        seg_demand = 1'b1;
        cyc();
        check_time("held_level_no_repeat", 0, 0);
        seg_demand = 1'b0;

        // 3. countdown from 01:00
        set_time(1, 0);
        forward = 1'b0;
        repeat (3) cyc();
        check("cnt_no_tick_early", int'(tick), 0);
        check_time("cnt_before_tick", 1, 0);
        cyc();
        check("cnt_tick1", int'(tick), 1);
        check_time("cnt_00_59", 0, 59);
        repeat (3) cyc();
        check("cnt_tick_gap", int'(tick), 0);
        cyc();
        check("cnt_tick2", int'(tick), 1);
        check_time("cnt_00_58", 0, 58);

        // 4. expiry from 00:02
        set_time(0, 2);
        forward = 1'b0;
        repeat (8) cyc();
        check_time("exp_time", 0, 0);
        check("exp_zero", int'(zero), 1);
        check("exp_state", int'(state), 3);
        check("exp_last_tick", int'(tick), 1);
`ifdef TIMER_ALARM_EN
        check("alarm_entry", int'(alarm), 1);
`else
        check("alarm_entry", int'(alarm), 0);
`endif
        repeat (2) cyc();
        check("alarm_low_phase", int'(alarm), 0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("exp_no_tick", int'(tick), 0);
            check("exp_stays", int'(state), 3);
        end
        check("alarm_expired_off", int'(alarm), 0);

        // 5. pause and resume from 00:10
        set_time(0, 10);
        forward = 1'b0;
        repeat (2) cyc();
        enable_counter = 1'b0;
        repeat (5) cyc();
        check_time("pause_frozen", 0, 10);
        check("pause_state", int'(state), 0);
        enable_counter = 1'b1;
        cyc();
        check("resume_no_tick", int'(tick), 0);
        cyc();
        check("resume_tick", int'(tick), 1);
        check_time("resume_00_09", 0, 9);

        // 6. reset_timer / reset in the wrap cycle at 00:05
        set_time(0, 5);
        forward = 1'b0;
        repeat (3) cyc();
        reset_timer = 1'b1;
        cyc();
        reset_timer = 1'b0;
        check_time("rt_wrap_time", 0, 0);
        check("rt_wrap_tick", int'(tick), 0);
        check("rt_wrap_state", int'(state), 0);
        set_time(0, 5);
        forward = 1'b0;
        repeat (3) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check_time("rst_wrap_time", 0, 0);
        check("rst_wrap_tick", int'(tick), 0);
        check("rst_wrap_state", int'(state), 0);

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            reset_timer = ($urandom_range(0, 79) == 0);
            enable_counter = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 19) == 0) forward = ~forward;
            if ($urandom_range(0, 2) == 0) seg_demand = ~seg_demand;
            if ($urandom_range(0, 4) == 0) min_demand = ~min_demand;
            cyc();
        end
        reset = 1'b0;
        reset_timer = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
